uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_byte_rx.sv | 157 +++++++++++++++
 rtl/uart_frame_rx.sv | 140 ++++++++++++++
 tb/tb_uart_frame_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART constants, receiver state encoding, baud divisor
// Rev 1.0
// ============================================================================
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_t;

   function automatic logic [31:0] baud_div(input logic [31:0] clk_freq,
                                            input logic [2:0]  sel);
      logic [31:0] baud;
      case (sel)
         3'd0:    baud = 32'd9600;
         3'd1:    baud = 32'd19200;
         3'd2:    baud = 32'd38400;
         3'd3:    baud = 32'd57600;
         default: baud = 32'd115200;
      endcase
      return clk_freq / baud;
   endfunction

   // Expected parity bit for a data byte; odd=1 selects odd parity.
   function automatic logic parity_bit(input logic [7:0] d, input logic odd);
      return odd ? ~(^d) : (^d);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// uart_byte_rx : bit-level receiver, 2-FF sync, majority-of-3 mid-bit sampling
// Rev 1.0
// ============================================================================
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned PARITY_MODE = PARITY_NONE
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  i_baud_sel,
   input  logic        i_rx,
   output logic [7:0]  o_byte,
   output logic        o_byte_valid,
   output logic        o_stop_err,
   output logic        o_par_err,
   output logic [15:0] o_line_idle_bits,
   output logic        o_start,
   output logic        o_busy
);

   localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);
   localparam bit ODD_PARITY = (PARITY_MODE == PARITY_ODD);

   logic [1:0]  r_sync;
   logic        r_prev;
   logic [2:0]  r_hist;
   rx_state_t   r_state;
   logic [31:0] r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic        r_par_ok;
   logic [31:0] r_idle_cnt;
   logic [15:0] r_idle_bits;

   logic        w_rx;
   logic        w_fall;
   logic        w_maj;
   logic        w_mid;
   logic        w_tick;
   logic        w_idle_tick;
   logic [31:0] w_div;
   logic [31:0] w_half;

   assign w_rx        = r_sync[1];
   assign w_fall      = r_prev & ~w_rx;
   assign w_maj       = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
   assign w_div       = baud_div(CLK_FREQ, i_baud_sel);
   assign w_half      = w_div >> 1;
   assign w_mid       = (r_cnt == w_half - 32'd1);
   assign w_tick      = (r_cnt == w_div - 32'd1);
   assign w_idle_tick = (r_idle_cnt == w_div - 32'd1);

   assign o_byte           = r_shift;
   assign o_start          = (r_state == ST_IDLE) && w_fall;
   assign o_busy           = (r_state != ST_IDLE);
   assign o_line_idle_bits = r_idle_bits;

   // START counts to mid-bit; every later bit is sampled one full period on.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync       <= 2'b11;
         r_prev       <= 1'b1;
         r_hist       <= 3'b111;
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_par_ok     <= 1'b1;
         o_byte_valid <= 1'b0;
         o_stop_err   <= 1'b0;
         o_par_err    <= 1'b0;
      end else begin
         r_sync       <= {r_sync[0], i_rx};
         r_prev       <= w_rx;
         r_hist       <= {r_hist[1:0], w_rx};
         o_byte_valid <= 1'b0;
         o_stop_err   <= 1'b0;
         o_par_err    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt    <= '0;
               r_bit    <= '0;
               r_par_ok <= 1'b1;
               if (w_fall) begin
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               r_cnt <= r_cnt + 32'd1;
               if (w_mid) begin
                  r_cnt   <= '0;
                  r_state <= w_maj ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               r_cnt <= r_cnt + 32'd1;
               if (w_tick) begin
                  r_cnt   <= '0;
                  r_shift <= {w_maj, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
                     r_state <= HAS_PARITY ? ST_PARITY : ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               r_cnt <= r_cnt + 32'd1;
               if (w_tick) begin
                  r_cnt    <= '0;
                  r_par_ok <= (w_maj == parity_bit(r_shift, ODD_PARITY));
                  r_state  <= ST_STOP;
               end
            end
            ST_STOP: begin
               r_cnt <= r_cnt + 32'd1;
               if (w_tick) begin
                  r_cnt        <= '0;
                  o_byte_valid <= w_maj & r_par_ok;
                  o_stop_err   <= ~w_maj;
                  o_par_err    <= ~r_par_ok;
                  r_state      <= w_maj ? ST_IDLE : ST_BREAK;
               end
            end
            ST_BREAK: begin
               if (w_rx) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Whole bit-times of high line seen while the FSM is idle, saturating.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idle_cnt  <= '0;
         r_idle_bits <= '0;
      end else if ((r_state != ST_IDLE) || !w_rx) begin
         r_idle_cnt  <= '0;
         r_idle_bits <= '0;
      end else if (w_idle_tick) begin
         r_idle_cnt <= '0;
         if (r_idle_bits != 16'hFFFF) begin
            r_idle_bits <= r_idle_bits + 16'd1;
         end
      end else begin
         r_idle_cnt <= r_idle_cnt + 32'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// uart_frame_rx : assembles DATA_WIDTH/8 UART bytes into one frame with status
// Rev 1.0
// ============================================================================
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 256,
   parameter int unsigned MSB_FIRST   = 0,
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned PARITY_MODE = PARITY_NONE,
   parameter int unsigned GAP_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            baud_set,
   input  logic                  uart_rx,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  rx_done,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  timeout_err,
   output logic                  uart_state
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [2:0]            r_baud;
   logic [CNT_W-1:0]      r_byte_cnt;
   logic [DATA_WIDTH-1:0] r_shadow;

   logic [DATA_WIDTH-1:0] w_shadow_next;
   logic [7:0]            w_byte;
   logic                  w_byte_valid;
   logic                  w_stop_err;
   logic                  w_par_err;
   logic [15:0]           w_idle_bits;
   logic                  w_start;
   logic                  w_busy;
   logic                  w_last;
   logic                  w_timeout;
   logic                  w_any_pulse;
   logic                  w_byte_event;

   uart_byte_rx #(
      .CLK_FREQ    (CLK_FREQ),
      .PARITY_MODE (PARITY_MODE)
   ) u_byte_rx (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_baud_sel       (r_baud),
      .i_rx             (uart_rx),
      .o_byte           (w_byte),
      .o_byte_valid     (w_byte_valid),
      .o_stop_err       (w_stop_err),
      .o_par_err        (w_par_err),
      .o_line_idle_bits (w_idle_bits),
      .o_start          (w_start),
      .o_busy           (w_busy)
   );

   assign w_last       = (r_byte_cnt == CNT_W'(NBYTES - 1));
   assign w_byte_event = w_byte_valid | w_stop_err | w_par_err;
   assign w_any_pulse  = rx_done | frame_err | parity_err | timeout_err;
   // A start edge in the same cycle always wins over the gap timeout.
   assign w_timeout    = (r_byte_cnt != '0) && !w_busy && !w_start &&
                         (w_idle_bits >= 16'(GAP_TIMEOUT));

   always_comb begin
      w_shadow_next = r_shadow;
      for (int k = 0; k < NBYTES; k++) begin
         if (CNT_W'(k) == r_byte_cnt) begin
            if (MSB_FIRST != 0) begin
               w_shadow_next[DATA_WIDTH-8-8*k +: 8] = w_byte;
            end else begin
               w_shadow_next[8*k +: 8] = w_byte;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_baud      <= '0;
         r_byte_cnt  <= '0;
         r_shadow    <= '0;
         data        <= '0;
         rx_done     <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         timeout_err <= 1'b0;
         uart_state  <= 1'b0;
      end else begin
         rx_done     <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         timeout_err <= 1'b0;

         // Baud select is frozen for the whole frame once it has begun.
         if (!uart_state) begin
            r_baud <= baud_set;
         end

         if (w_byte_valid) begin
            if (w_last) begin
               data       <= w_shadow_next;
               r_shadow   <= '0;
               r_byte_cnt <= '0;
               rx_done    <= 1'b1;
            end else begin
               r_shadow   <= w_shadow_next;
               r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
         end else if (w_stop_err || w_par_err) begin
            frame_err  <= w_stop_err;
            parity_err <= w_par_err;
            r_shadow   <= '0;
            r_byte_cnt <= '0;
         end else if (w_timeout) begin
            timeout_err <= 1'b1;
            r_shadow    <= '0;
            r_byte_cnt  <= '0;
         end

         // Status stays high through the terminating pulse cycle; a false
         // start on byte 0 drops it once the byte receiver is idle again.
         if (w_start) begin
            uart_state <= 1'b1;
         end else if (w_any_pulse) begin
            uart_state <= 1'b0;
         end else if (uart_state && !w_busy && !w_byte_event && (r_byte_cnt == '0)) begin
            uart_state <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_frame_rx : directed bench for uart_frame_rx (LSB/MSB order, parity)
// Rev 1.0
// ============================================================================
module tb_uart_frame_rx;

   localparam int unsigned CLK_FREQ = 1_843_200;   // 16 clocks per bit at 115200
   localparam int          DIV      = 16;
   localparam logic [255:0] D1 = 256'h890abcdef12312345abcdef674567890cba0987654fed365432121fedcba0987;
   localparam logic [255:0] D2 = 256'hcba0987654fed365432121fedcba0987ba09876fe321dc54b321dc6fe54a0978;

   logic         clk      = 1'b0;
   logic         reset_n  = 1'b0;
   logic [2:0]   baud_set = 3'd4;
   logic         line_a   = 1'b1;
   logic         line_p   = 1'b1;

   logic [255:0] data0, data1, data2;
   logic         done0, ferr0, perr0, tout0, st0;
   logic         done1, ferr1, perr1, tout1, st1;
   logic         done2, ferr2, perr2, tout2, st2;

   int n_done0 = 0, n_ferr0 = 0, n_perr0 = 0, n_tout0 = 0;
   int n_done1 = 0, n_ferr1 = 0, n_perr1 = 0, n_tout1 = 0;
   int n_done2 = 0, n_ferr2 = 0, n_perr2 = 0, n_tout2 = 0;
   int n_overlap = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_frame_rx #(.DATA_WIDTH(256), .MSB_FIRST(0), .CLK_FREQ(CLK_FREQ), .PARITY_MODE(0), .GAP_TIMEOUT(16)) dut0 (
      .clk(clk), .reset_n(reset_n), .baud_set(baud_set), .uart_rx(line_a), .data(data0), .rx_done(done0),
      .frame_err(ferr0), .parity_err(perr0), .timeout_err(tout0), .uart_state(st0));
   uart_frame_rx #(.DATA_WIDTH(256), .MSB_FIRST(1), .CLK_FREQ(CLK_FREQ), .PARITY_MODE(0), .GAP_TIMEOUT(16)) dut1 (
      .clk(clk), .reset_n(reset_n), .baud_set(baud_set), .uart_rx(line_a), .data(data1), .rx_done(done1),
      .frame_err(ferr1), .parity_err(perr1), .timeout_err(tout1), .uart_state(st1));
   uart_frame_rx #(.DATA_WIDTH(256), .MSB_FIRST(0), .CLK_FREQ(CLK_FREQ), .PARITY_MODE(2), .GAP_TIMEOUT(16)) dut2 (
      .clk(clk), .reset_n(reset_n), .baud_set(baud_set), .uart_rx(line_p), .data(data2), .rx_done(done2),
      .frame_err(ferr2), .parity_err(perr2), .timeout_err(tout2), .uart_state(st2));

   always @(negedge clk) begin
      if (done0) n_done0++;
      if (ferr0) n_ferr0++;
      if (perr0) n_perr0++;
      if (tout0) n_tout0++;
      if (done1) n_done1++;
      if (ferr1) n_ferr1++;
      if (perr1) n_perr1++;
      if (tout1) n_tout1++;
      if (done2) n_done2++;
      if (ferr2) n_ferr2++;
      if (perr2) n_perr2++;
      if (tout2) n_tout2++;
      if ((done0 && (ferr0 || perr0 || tout0)) || (done1 && (ferr1 || perr1 || tout1)) ||
          (done2 && (ferr2 || perr2 || tout2)))
         n_overlap++;
   end

   function automatic logic [255:0] bswap(input logic [255:0] d);
      logic [255:0] r;
      for (int k = 0; k < 32; k++) r[8*k +: 8] = d[255-8*k -: 8];
      return r;
   endfunction

   function automatic int errs_a();
      return n_ferr0 + n_perr0 + n_tout0 + n_ferr1 + n_perr1 + n_tout1;
   endfunction

   task automatic wait_bits(input int n);
      repeat (n * DIV) @(negedge clk);
   endtask

   task automatic send_a(input logic [7:0] b, input logic stop);
      line_a = 1'b0;
      wait_bits(1);
      for (int i = 0; i < 8; i++) begin
         line_a = b[i];
         wait_bits(1);
      end
      line_a = stop;
      wait_bits(1);
      line_a = 1'b1;
   endtask

   task automatic send_p(input logic [7:0] b, input logic flip);
      line_p = 1'b0;
      wait_bits(1);
      for (int i = 0; i < 8; i++) begin
         line_p = b[i];
         wait_bits(1);
      end
      line_p = (^b) ^ flip;
      wait_bits(1);
      line_p = 1'b1;
      wait_bits(1);
   endtask

   task automatic send_bytes_a(input logic [255:0] d, input bit msb_order, input int first, input int count);
      logic [7:0] b;
      for (int k = first; k < first + count; k++) begin
         b = msb_order ? d[255-8*k -: 8] : d[8*k +: 8];
         send_a(b, 1'b1);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      if (data0 !== 256'd0) begin errors++; $display("FAIL reset_data0: got %h want 0", data0); end
      checks++;
      if (data2 !== 256'd0) begin errors++; $display("FAIL reset_data2: got %h want 0", data2); end
      checks++;
      if ({done0, ferr0, perr0, tout0, st0} !== 5'b0) begin
         errors++; $display("FAIL reset_flags0: got %b want 00000", {done0, ferr0, perr0, tout0, st0}); end
      checks++;
      if ({done2, ferr2, perr2, tout2, st2} !== 5'b0) begin
         errors++; $display("FAIL reset_flags2: got %b want 00000", {done2, ferr2, perr2, tout2, st2}); end
      checks++;
      reset_n = 1'b1;
      wait_bits(4);
   endtask

   task automatic test_lsb_frame;
      int b_done0 = n_done0, b_done1 = n_done1, b_err = errs_a();
      send_bytes_a(D1, 1'b0, 0, 32);
      wait_bits(2);
      if (n_done0 - b_done0 !== 1) begin errors++; $display("FAIL lsb_done0: got %0d want 1", n_done0 - b_done0); end
      checks++;
      if (data0 !== D1) begin errors++; $display("FAIL lsb_data0: got %h want %h", data0, D1); end
      checks++;
      if (n_done1 - b_done1 !== 1) begin errors++; $display("FAIL lsb_done1: got %0d want 1", n_done1 - b_done1); end
      checks++;
      if (data1 !== bswap(D1)) begin errors++; $display("FAIL lsb_data1: got %h want %h", data1, bswap(D1)); end
      checks++;
      if (errs_a() - b_err !== 0) begin errors++; $display("FAIL lsb_errs: got %0d want 0", errs_a() - b_err); end
      checks++;
      if (st0 !== 1'b0) begin errors++; $display("FAIL lsb_state: got %b want 0", st0); end
      checks++;
   endtask

   task automatic test_msb_frame;
      int b_done1 = n_done1, b_err = errs_a();
      send_bytes_a(D2, 1'b1, 0, 16);
      if (data0 !== D1) begin errors++; $display("FAIL msb_hold0: got %h want %h", data0, D1); end
      checks++;
      if (st1 !== 1'b1) begin errors++; $display("FAIL msb_state_mid: got %b want 1", st1); end
      checks++;
      send_bytes_a(D2, 1'b1, 16, 16);
      wait_bits(2);
      if (data1 !== D2) begin errors++; $display("FAIL msb_data1: got %h want %h", data1, D2); end
      checks++;
      if (data0 !== bswap(D2)) begin errors++; $display("FAIL msb_data0: got %h want %h", data0, bswap(D2)); end
      checks++;
      if (n_done1 - b_done1 !== 1) begin errors++; $display("FAIL msb_done1: got %0d want 1", n_done1 - b_done1); end
      checks++;
      if (errs_a() - b_err !== 0) begin errors++; $display("FAIL msb_errs: got %0d want 0", errs_a() - b_err); end
      checks++;
   endtask

   task automatic test_parity;
      int b_done = n_done2, b_perr = n_perr2, b_ferr = n_ferr2, b_tout = n_tout2;
      for (int k = 0; k < 4; k++) send_p(D1[8*k +: 8], (k == 3));
      wait_bits(2);
      if (n_perr2 - b_perr !== 1) begin errors++; $display("FAIL par_perr: got %0d want 1", n_perr2 - b_perr); end
      checks++;
      if (n_done2 - b_done !== 0) begin errors++; $display("FAIL par_nodone: got %0d want 0", n_done2 - b_done); end
      checks++;
      if (n_ferr2 - b_ferr !== 0) begin errors++; $display("FAIL par_ferr: got %0d want 0", n_ferr2 - b_ferr); end
      checks++;
      if (st2 !== 1'b0) begin errors++; $display("FAIL par_state: got %b want 0", st2); end
      checks++;
      if (data2 !== 256'd0) begin errors++; $display("FAIL par_data_hold: got %h want 0", data2); end
      checks++;
      wait_bits(4);
      for (int k = 0; k < 32; k++) send_p(D1[8*k +: 8], 1'b0);
      wait_bits(2);
      if (data2 !== D1) begin errors++; $display("FAIL par_data: got %h want %h", data2, D1); end
      checks++;
      if (n_done2 - b_done !== 1) begin errors++; $display("FAIL par_done: got %0d want 1", n_done2 - b_done); end
      checks++;
      if (n_perr2 - b_perr + n_tout2 - b_tout !== 1) begin
         errors++; $display("FAIL par_other_errs: got %0d want 1", n_perr2 - b_perr + n_tout2 - b_tout); end
      checks++;
   endtask

   task automatic test_frame_err;
      int b_f0 = n_ferr0, b_f1 = n_ferr1, b_d0 = n_done0;
      send_a(8'hA5, 1'b0);
      wait_bits(2);
      if (n_ferr0 - b_f0 !== 1) begin errors++; $display("FAIL ferr_pulse0: got %0d want 1", n_ferr0 - b_f0); end
      checks++;
      if (n_ferr1 - b_f1 !== 1) begin errors++; $display("FAIL ferr_pulse1: got %0d want 1", n_ferr1 - b_f1); end
      checks++;
      if (data0 !== bswap(D2)) begin errors++; $display("FAIL ferr_hold0: got %h want %h", data0, bswap(D2)); end
      checks++;
      if (data1 !== D2) begin errors++; $display("FAIL ferr_hold1: got %h want %h", data1, D2); end
      checks++;
      if (st0 !== 1'b0) begin errors++; $display("FAIL ferr_state: got %b want 0", st0); end
      checks++;
      if (n_done0 - b_d0 !== 0) begin errors++; $display("FAIL ferr_nodone: got %0d want 0", n_done0 - b_d0); end
      checks++;
      wait_bits(2);
   endtask

   task automatic test_timeout;
      int b_t0 = n_tout0, b_t1 = n_tout1, b_d0 = n_done0;
      send_bytes_a(D1, 1'b0, 0, 5);
      if (st0 !== 1'b1) begin errors++; $display("FAIL tout_state_busy: got %b want 1", st0); end
      checks++;
      if (n_tout0 - b_t0 !== 0) begin errors++; $display("FAIL tout_early: got %0d want 0", n_tout0 - b_t0); end
      checks++;
      wait_bits(17);
      if (n_tout0 - b_t0 !== 1) begin errors++; $display("FAIL tout_pulse0: got %0d want 1", n_tout0 - b_t0); end
      checks++;
      if (n_tout1 - b_t1 !== 1) begin errors++; $display("FAIL tout_pulse1: got %0d want 1", n_tout1 - b_t1); end
      checks++;
      if (st0 !== 1'b0) begin errors++; $display("FAIL tout_state: got %b want 0", st0); end
      checks++;
      send_bytes_a(D1, 1'b0, 0, 32);
      wait_bits(2);
      if (data0 !== D1) begin errors++; $display("FAIL tout_next_data: got %h want %h", data0, D1); end
      checks++;
      if (n_done0 - b_d0 !== 1) begin errors++; $display("FAIL tout_next_done: got %0d want 1", n_done0 - b_d0); end
      checks++;
   endtask

   task automatic test_glitch_reset;
      int b_d0 = n_done0, b_err = errs_a();
      line_a = 1'b0;
      repeat (5) @(negedge clk);
      line_a = 1'b1;
      wait_bits(3);
      if (st0 !== 1'b0) begin errors++; $display("FAIL glitch_state: got %b want 0", st0); end
      checks++;
      if (errs_a() - b_err !== 0) begin errors++; $display("FAIL glitch_errs: got %0d want 0", errs_a() - b_err); end
      checks++;
      send_bytes_a(D2, 1'b0, 0, 10);
      line_a = 1'b0;
      wait_bits(1);
      for (int i = 0; i < 3; i++) begin
         line_a = D2[80 + i];
         wait_bits(1);
      end
      #2 reset_n = 1'b0;
      line_a = 1'b1;
      repeat (3) @(negedge clk);
      if (data0 !== 256'd0) begin errors++; $display("FAIL rst_data0: got %h want 0", data0); end
      checks++;
      if (data1 !== 256'd0) begin errors++; $display("FAIL rst_data1: got %h want 0", data1); end
      checks++;
      if ({done0, st0, st1} !== 3'b0) begin errors++; $display("FAIL rst_flags: got %b want 000", {done0, st0, st1}); end
      checks++;
      reset_n = 1'b1;
      wait_bits(3);
      send_bytes_a(D1, 1'b0, 0, 32);
      wait_bits(2);
      if (data0 !== D1) begin errors++; $display("FAIL rst_next_data: got %h want %h", data0, D1); end
      checks++;
      if (n_done0 - b_d0 !== 1) begin errors++; $display("FAIL rst_next_done: got %0d want 1", n_done0 - b_d0); end
      checks++;
      if (errs_a() - b_err !== 0) begin errors++; $display("FAIL rst_errs: got %0d want 0", errs_a() - b_err); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_lsb_frame();
      test_msb_frame();
      test_parity();
      test_frame_err();
      test_timeout();
      test_glitch_reset();
      if (n_overlap !== 0) begin errors++; $display("FAIL done_err_overlap: got %0d want 0", n_overlap); end
      checks++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
